// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings,
// reset/hold levels, stage indices and a small helper.
package pipe_ctrl_pkg;

  // Pipeline FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_EXBUSY  = 2'd1,
    PC_BUSWAIT = 2'd2,
    PC_DRAIN   = 2'd3
  } pc_state_t;

  // Reset is asserted low; a stall/hold request is asserted high.
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic HOLD_ENABLE = 1'b1;

  // Default width of jump and vector targets.
  localparam int DEF_ADDR_W = 32;

  // Stage indices for the per-stage control vectors.
  // The PC stage can only be stalled; the other two can also be flushed.
  localparam int STG_PC   = 0;
  localparam int STG_IFID = 1;
  localparam int STG_IDEX = 2;
  localparam int N_STG    = 3;

  // Interrupt drain counter width; holds DRAIN_CYC-1 for DRAIN_CYC in 1..15.
  localparam int DCNT_W = 4;

  // Hold request for every stage at once.
  function automatic logic [N_STG-1:0] stall_all();
    return {N_STG{HOLD_ENABLE}};
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: advances once per enabled cycle and sticks at
// all-ones instead of wrapping. Clears on asynchronous active-low reset.
module sat_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // Increment unless already at the saturation value.
  always_comb begin
    count_next = count_reg;
    if (en && !(&count_reg)) begin
      count_next = count_reg + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the RV32I core. Turns hazard, jump, multi-cycle EX,
// bus-wait and interrupt events into stall/flush controls for the PC, IF/ID
// and ID/EX registers plus the PC redirect. All controls are combinational
// from the current state and inputs; only the state, the drain counter and
// the stall performance counter are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_use_i,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jaddr_i,
  input  logic              ex_busy_i,
  input  logic              bus_wait_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_vec_i,
  output logic              stall_pc_o,
  output logic              stall_ifid_o,
  output logic              stall_idex_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jaddr_o,
  output logic              irq_ack_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  pc_state_t state_reg;
  pc_state_t state_next;

  logic [DCNT_W-1:0] drain_cnt_reg;
  logic [DCNT_W-1:0] drain_cnt_next;

  // Raw decode results before reset masking and flush-over-stall priority.
  logic [N_STG-1:0]  stall_raw;
  logic [N_STG-1:0]  flush_raw;
  logic              jump_raw;
  logic [ADDR_W-1:0] jaddr_raw;
  logic              ack_raw;
  logic              run_eval;

  // Final per-stage controls; the PC stage has no flush.
  logic [N_STG-1:0]  stall_v;
  logic [N_STG-1:1]  flush_v;

  logic rst_active;

  assign rst_active = (rst == RST_ENABLE);

  // Next-state and control decode. EXBUSY/BUSWAIT hold everything while
  // their condition persists and otherwise fall through to the RUN rules in
  // the same cycle, so a jump on a release cycle is not lost.
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    stall_raw      = '0;
    flush_raw      = '0;
    jump_raw       = 1'b0;
    jaddr_raw      = '0;
    ack_raw        = 1'b0;
    run_eval       = 1'b0;

    case (state_reg)
      PC_EXBUSY: begin
        if (ex_busy_i) begin
          stall_raw = stall_all();
        end else begin
          run_eval = 1'b1;
        end
      end

      PC_BUSWAIT: begin
        // ex_busy_i rising while the bus still waits keeps us here.
        if (bus_wait_i) begin
          stall_raw = stall_all();
        end else begin
          run_eval = 1'b1;
        end
      end

      PC_DRAIN: begin
        // Committed to the interrupt: jumps and load-use are ignored and a
        // dropped request no longer matters.
        flush_raw[STG_IFID] = 1'b1;
        flush_raw[STG_IDEX] = 1'b1;
        if (drain_cnt_reg == '0) begin
          jump_raw   = 1'b1;
          jaddr_raw  = irq_vec_i;
          ack_raw    = 1'b1;
          state_next = PC_RUN;
        end else begin
          stall_raw[STG_PC] = 1'b1;
          drain_cnt_next    = drain_cnt_reg - DCNT_W'(1);
        end
      end

      default: begin
        run_eval = 1'b1;
      end
    endcase

    if (run_eval) begin
      state_next = PC_RUN;
      if (ex_jump_i) begin
        // A resolved jump kills the younger instructions; busy/wait are moot.
        jump_raw            = 1'b1;
        jaddr_raw           = ex_jaddr_i;
        flush_raw[STG_IFID] = 1'b1;
        flush_raw[STG_IDEX] = 1'b1;
      end else if (ex_busy_i) begin
        stall_raw  = stall_all();
        state_next = PC_EXBUSY;
      end else if (bus_wait_i) begin
        stall_raw  = stall_all();
        state_next = PC_BUSWAIT;
      end else if (irq_req_i) begin
        flush_raw[STG_IFID] = 1'b1;
        flush_raw[STG_IDEX] = 1'b1;
        stall_raw[STG_PC]   = 1'b1;
        drain_cnt_next      = DCNT_W'(DRAIN_CYC - 1);
        state_next          = PC_DRAIN;
      end else if (ld_use_i) begin
        // Hold the front end one cycle and insert a single bubble into EX.
        stall_raw[STG_PC]   = 1'b1;
        stall_raw[STG_IFID] = 1'b1;
        flush_raw[STG_IDEX] = 1'b1;
      end
    end
  end

  // FSM state and drain counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= PC_RUN;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // Per-stage resolution: flush beats stall, and reset forces every
  // flushable stage to its bubble while releasing all stalls.
  for (genvar gi = 0; gi < N_STG; gi++) begin : g_stage
    assign stall_v[gi] = !rst_active && stall_raw[gi] && !flush_raw[gi];
    if (gi != STG_PC) begin : g_flush
      assign flush_v[gi] = rst_active || flush_raw[gi];
    end
  end

  assign stall_pc_o   = stall_v[STG_PC];
  assign stall_ifid_o = stall_v[STG_IFID];
  assign stall_idex_o = stall_v[STG_IDEX];
  assign flush_ifid_o = flush_v[STG_IFID];
  assign flush_idex_o = flush_v[STG_IDEX];
  assign jump_o       = !rst_active && jump_raw;
  assign jaddr_o      = rst_active ? '0 : jaddr_raw;
  assign irq_ack_o    = !rst_active && ack_raw;

  // Performance counter of PC-stall cycles.
  sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_pc_o),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with DRAIN_CYC=2 and a 4-bit stall counter.
// Each vector: step past a rising edge, apply inputs, let the combinational
// controls settle, then compare against hand-computed values.
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              ld_use_i;
  logic              ex_jump_i;
  logic [ADDR_W-1:0] ex_jaddr_i;
  logic              ex_busy_i;
  logic              bus_wait_i;
  logic              irq_req_i;
  logic [ADDR_W-1:0] irq_vec_i;
  logic              stall_pc_o;
  logic              stall_ifid_o;
  logic              stall_idex_o;
  logic              flush_ifid_o;
  logic              flush_idex_o;
  logic              jump_o;
  logic [ADDR_W-1:0] jaddr_o;
  logic              irq_ack_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Control bundle: {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, jump, ack}
  localparam logic [6:0] C_IDLE  = 7'b000_00_0_0;
  localparam logic [6:0] C_RST   = 7'b000_11_0_0;
  localparam logic [6:0] C_LDUSE = 7'b110_01_0_0;
  localparam logic [6:0] C_JUMP  = 7'b000_11_1_0;
  localparam logic [6:0] C_STALL = 7'b111_00_0_0;
  localparam logic [6:0] C_DRAIN = 7'b100_11_0_0;
  localparam logic [6:0] C_IRQ   = 7'b000_11_1_1;

  logic [6:0] ctl;
  assign ctl = {stall_pc_o, stall_ifid_o, stall_idex_o,
                flush_ifid_o, flush_idex_o, jump_o, irq_ack_o};

  pipe_ctrl #(
    .ADDR_W    (ADDR_W),
    .DRAIN_CYC (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_use_i     (ld_use_i),
    .ex_jump_i    (ex_jump_i),
    .ex_jaddr_i   (ex_jaddr_i),
    .ex_busy_i    (ex_busy_i),
    .bus_wait_i   (bus_wait_i),
    .irq_req_i    (irq_req_i),
    .irq_vec_i    (irq_vec_i),
    .stall_pc_o   (stall_pc_o),
    .stall_ifid_o (stall_ifid_o),
    .stall_idex_o (stall_idex_o),
    .flush_ifid_o (flush_ifid_o),
    .flush_idex_o (flush_idex_o),
    .jump_o       (jump_o),
    .jaddr_o      (jaddr_o),
    .irq_ack_o    (irq_ack_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    $display("[%0t] %s ctl=%b", $time, tag, ctl);
    chk(tag, {25'd0, ctl}, {25'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ld_use_i   = 1'b0;
    ex_jump_i  = 1'b0;
    ex_jaddr_i = '0;
    ex_busy_i  = 1'b0;
    bus_wait_i = 1'b0;
    irq_req_i  = 1'b0;
    irq_vec_i  = '0;
  endtask

  // Assert reset for one edge, check the reset view, release after the edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk_ctl({tag, "_rst_ctl"}, C_RST);
    chk({tag, "_rst_cnt"}, 32'(stall_cnt_o), 32'd0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();

    // Reset view and first RUN cycle.
    #2;
    chk_ctl("por_ctl", C_RST);
    chk("por_jaddr", jaddr_o, 32'h0);
    chk("por_cnt", 32'(stall_cnt_o), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk_ctl("run_idle", C_IDLE);

    // Load-use: one bubble, one stalled PC cycle.
    tick(); ld_use_i = 1'b1; #1;
    chk_ctl("lduse", C_LDUSE);
    tick(); ld_use_i = 1'b0; #1;
    chk_ctl("lduse_after", C_IDLE);
    chk("lduse_cnt", 32'(stall_cnt_o), 32'd1);

    // Jump beats busy in the same cycle.
    tick(); ex_jump_i = 1'b1; ex_jaddr_i = 32'h0000_0100; ex_busy_i = 1'b1; #1;
    chk_ctl("jump_busy", C_JUMP);
    chk("jump_busy_addr", jaddr_o, 32'h0000_0100);
    tick(); clear_inputs(); #1;
    chk_ctl("jump_after", C_IDLE);
    chk("jump_cnt", 32'(stall_cnt_o), 32'd1);

    // Bus wait, busy rising during wait, hand-off to EXBUSY, jump on release.
    tick(); bus_wait_i = 1'b1; #1;
    chk_ctl("bw_1", C_STALL);
    tick(); ex_busy_i = 1'b1; #1;
    chk_ctl("bw_busy", C_STALL);
    tick(); bus_wait_i = 1'b0; #1;
    chk_ctl("bw_to_busy", C_STALL);
    tick(); ex_busy_i = 1'b0; ex_jump_i = 1'b1; ex_jaddr_i = 32'h0000_0080; #1;
    chk_ctl("busy_rel_jump", C_JUMP);
    chk("busy_rel_addr", jaddr_o, 32'h0000_0080);
    tick(); clear_inputs(); #1;
    chk_ctl("bw_after", C_IDLE);
    chk("bw_cnt", 32'(stall_cnt_o), 32'd4);

    // Multi-cycle EX: five stalled cycles then release.
    do_reset("mc");
    for (int i = 0; i < 5; i++) begin
      tick(); ex_busy_i = 1'b1; #1;
      chk_ctl($sformatf("mc_busy%0d", i), C_STALL);
    end
    tick(); ex_busy_i = 1'b0; #1;
    chk_ctl("mc_release", C_IDLE);
    chk("mc_cnt", 32'(stall_cnt_o), 32'd5);

    // Interrupt with DRAIN_CYC=2; request dropped and jump/ld_use raised
    // during the drain must not change anything.
    do_reset("irq");
    tick(); irq_vec_i = 32'h0000_0040; irq_req_i = 1'b1; #1;
    chk_ctl("irq_enter", C_DRAIN);
    tick(); irq_req_i = 1'b0; ex_jump_i = 1'b1; ex_jaddr_i = 32'h0000_0200; ld_use_i = 1'b1; #1;
    chk_ctl("irq_drain", C_DRAIN);
    tick(); #1;
    chk_ctl("irq_redirect", C_IRQ);
    chk("irq_addr", jaddr_o, 32'h0000_0040);
    tick(); ex_jump_i = 1'b0; ld_use_i = 1'b0; #1;
    chk_ctl("irq_back_run", C_IDLE);
    chk("irq_cnt", 32'(stall_cnt_o), 32'd2);

    // Reset in the middle of DRAIN discards the interrupt.
    tick(); irq_req_i = 1'b1; #1;
    chk_ctl("rd_enter", C_DRAIN);
    tick(); rst = 1'b0; #1;
    chk_ctl("rd_in_rst", C_RST);
    chk("rd_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rd_jaddr", jaddr_o, 32'h0);
    tick(); rst = 1'b1; irq_req_i = 1'b0; #1;
    chk_ctl("rd_release", C_IDLE);
    tick(); #1;
    chk_ctl("rd_no_ack", C_IDLE);

    // Saturation of the 4-bit counter under a long bus wait.
    do_reset("sat");
    for (int i = 0; i < 20; i++) begin
      tick(); bus_wait_i = 1'b1; #1;
      if (i == 0)  chk_ctl("sat_stall", C_STALL);
      if (i == 10) chk("sat_cnt10", 32'(stall_cnt_o), 32'd10);
      if (i == 16) chk("sat_cnt16", 32'(stall_cnt_o), 32'd15);
    end
    tick(); bus_wait_i = 1'b0; #1;
    chk_ctl("sat_release", C_IDLE);
    chk("sat_final", 32'(stall_cnt_o), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
